cmd_loader: RTL and testbench
=============================

Name: cmd_loader

Overview:
- Parses a TRS-80 /CMD program image streamed from hps_io (ioctl byte stream, index CMD_INDEX) and turns it into byte writes into the HT1080Z RAM plus an optional execute request.
- Sits between hps_io and the ht1080z download/memory port in the top level.
- Holds the CPU (loader_en) for the whole download.
- Throttles hps_io through ioctl_wait while each memory write is pending.

Parameters:
- CMD_INDEX, 8'd2, ioctl_index value that selects CMD parsing; every other index is ignored.

Ports:
- clk_sys  in  1  system clock, 42 MHz.
- reset  in  1  asynchronous, active-low.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download file index.
- ioctl_wr  in  1  one-cycle strobe, byte valid on ioctl_dout.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  stall hps_io; no ioctl_wr is accepted while high.
- mem_addr  out  16  RAM write address.
- mem_data  out  8  RAM write data.
- mem_wr  out  1  write request, held until mem_ack.
- mem_ack  in  1  write accepted; may arrive in the same cycle mem_wr rises or later.
- loader_en  out  1  hold the CPU and give the bus to the loader.
- exec_req  out  1  jump to exec_addr requested; held until exec_ack.
- exec_addr  out  16  transfer address.
- exec_ack  in  1  CPU jump taken.
- err  out  1  malformed or truncated file; sticky until the next CMD download starts.

Behaviour:
- Reset (reset=0): every output = 0; state = IDLE. Reset mid-operation drops mem_wr immediately; the partial image is abandoned.
- Start: rising edge of ioctl_download with ioctl_index == CMD_INDEX → loader_en=1, err=0, exec_req=0, internal exec_valid=0, state TYPE. Downloads with any other index are ignored entirely.
- Byte consumption: only on ioctl_wr=1 while ioctl_wait=0.
- States:
  - TYPE: latch type byte.
    - 01 → LEN.
    - 02 → LEN.
    - 00 → DRAIN.
    - 03..1F → LEN, then SKIP.
    - ≥20 → err=1, DRAIN.
  - LEN: latch len.
    - type 01: data count cnt (9 bits) = ((len-2) mod 256), with 0 meaning 256. So len 02→256, 00→254, 01→255, 05→3. Next ADLO.
    - type 02: next XLO; len is ignored.
    - other types: skip count = len, with 0 meaning 256. Next SKIP.
  - ADLO/ADHI: load mem_addr low then high byte. ADHI → DATA.
  - DATA: on a byte, mem_data=byte, mem_wr=1, ioctl_wait=1 from the next cycle; go to WRITE.
  - WRITE: hold mem_wr, mem_addr and mem_data stable until mem_ack=1. On that cycle:
    - mem_wr=0, ioctl_wait=0.
    - mem_addr increments, wrapping FFFF→0000.
    - cnt decrements.
    - cnt reaches 0 → TYPE, else DATA.
  - SKIP: discard bytes; count reaching 0 → TYPE.
  - XLO/XHI: latch exec_addr; set exec_valid=1; go to DRAIN. All bytes after a transfer block are ignored.
  - DRAIN: discard all bytes until the download ends.
- End of download (falling ioctl_download, any state):
  - If not in TYPE, DRAIN or IDLE → err=1 (truncated file).
  - If mem_wr is pending, wait for mem_ack first; ioctl_wait stays as is.
  - loader_en drops one cycle after the last write completes.
  - exec_req=1 in the same cycle only if exec_valid and !err; cleared on exec_ack.
  - State returns to IDLE.
- Latency: the first mem_wr rises 1 cycle after the accepting ioctl_wr.
- Throughput: one byte per (2 + mem_ack delay) cycles.
- Simultaneous events:
  - ioctl_wr while ioctl_wait=1 is a protocol violation and is ignored.
  - A new download start while exec_req=1 clears exec_req.
- loader_en and exec_req are never both 1.

Test Plan:
- Stream 01 05 00 52 AA BB CC 02 02 2D 52, mem_ack tied 1 → writes 5200=AA, 5201=BB, 5202=CC in order; after download end, exec_req=1 with exec_addr=522D; clears on exec_ack; err=0.
- Stream 01 02 00 60 then 256 bytes 00..FF → exactly 256 writes 6000..60FF with data = low address byte; then 01 00 FF FF then 254 bytes → writes wrap FFFF→0000..00FC.
- Stream 05 03 41 42 43 01 03 00 70 11 → header skipped; single write 7000=11; no exec_req.
- mem_ack delayed 5 cycles per write → ioctl_wait high 6 cycles per byte; mem_addr, mem_data and mem_wr stable throughout; no byte lost.
- Download ends after 01 05 00 52 AA → one write 5200=AA, err=1, exec_req never asserts, loader_en drops. Separately, type byte 2A → err=1, no writes.
- Assert reset during WRITE → all outputs 0 next edge. Separately, run an index 1 download → no loader_en, no mem_wr.

Source files
------------

// File: rtl/cmd_loader_if.sv
// cmd_loader_if: hps_io download stream, RAM write port and exec handshake seen by the CMD loader
interface cmd_loader_if;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_wr;
   logic        mem_ack;
   logic        loader_en;
   logic        exec_req;
   logic [15:0] exec_addr;
   logic        exec_ack;
   logic        err;
   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, mem_ack, exec_ack,
      input  ioctl_wait, mem_addr, mem_data, mem_wr, loader_en, exec_req, exec_addr, err
   );
   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, mem_ack, exec_ack,
      output ioctl_wait, mem_addr, mem_data, mem_wr, loader_en, exec_req, exec_addr, err
   );
endinterface

// File: rtl/cmd_loader.sv
// cmd_loader: parses a TRS-80 /CMD image from the hps_io byte stream into RAM writes and an exec request
module cmd_loader #(
   parameter logic [7:0] CMD_INDEX = 8'd2
) (
   input logic         clk_sys,
   input logic         reset,
   cmd_loader_if.slave bus
);
   typedef enum logic [3:0] {IDLE, TYPE, LEN, ADLO, ADHI, DATA, WRITE, SKIP, XLO, XHI, DRAIN, FLUSH} state_t;
   state_t      state_q, state_d;
   logic        dl_q;
   logic [7:0]  type_q, type_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        wr_q, wr_d;
   logic        wait_q, wait_d;
   logic        en_q, en_d;
   logic        xreq_q, xreq_d;
   logic [15:0] xaddr_q, xaddr_d;
   logic        xvalid_q, xvalid_d;
   logic        err_q, err_d;
   logic        start, stop, acc, trunc;
   logic [7:0]  len_m2;
   assign start  = bus.ioctl_download && !dl_q && bus.ioctl_index == CMD_INDEX;
   assign stop   = !bus.ioctl_download && dl_q;
   assign acc    = bus.ioctl_wr && !wait_q;
   assign trunc  = !(state_q == IDLE || state_q == TYPE || state_q == DRAIN);
   assign len_m2 = bus.ioctl_dout - 8'd2;
   assign bus.ioctl_wait = wait_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_data   = data_q;
   assign bus.mem_wr     = wr_q;
   assign bus.loader_en  = en_q;
   assign bus.exec_req   = xreq_q;
   assign bus.exec_addr  = xaddr_q;
   assign bus.err        = err_q;
   // state and datapath registers; async active-low reset abandons any partial image
   always_ff @(posedge clk_sys or negedge reset)
      if (!reset) begin
         state_q  <= IDLE;
         dl_q     <= 1'b0;
         type_q   <= 8'h00;
         cnt_q    <= 9'd0;
         addr_q   <= 16'h0000;
         data_q   <= 8'h00;
         wr_q     <= 1'b0;
         wait_q   <= 1'b0;
         en_q     <= 1'b0;
         xreq_q   <= 1'b0;
         xaddr_q  <= 16'h0000;
         xvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dl_q     <= bus.ioctl_download;
         type_q   <= type_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         wr_q     <= wr_d;
         wait_q   <= wait_d;
         en_q     <= en_d;
         xreq_q   <= xreq_d;
         xaddr_q  <= xaddr_d;
         xvalid_q <= xvalid_d;
         err_q    <= err_d;
      end
   // record parser: start/end of download take priority over per-state byte handling
   always_comb begin
      state_d  = state_q;
      type_d   = type_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_d     = wr_q;
      wait_d   = wait_q;
      en_d     = en_q;
      xreq_d   = xreq_q && !bus.exec_ack;
      xaddr_d  = xaddr_q;
      xvalid_d = xvalid_q;
      err_d    = err_q;
      if (start) begin
         state_d  = TYPE;
         en_d     = 1'b1;
         err_d    = 1'b0;
         xreq_d   = 1'b0;
         xvalid_d = 1'b0;
         wr_d     = 1'b0;
         wait_d   = 1'b0;
      end else if (stop && state_q != IDLE) begin
         err_d = err_q || trunc;
         if (state_q == WRITE && !bus.mem_ack)
            state_d = FLUSH;
         else begin
            state_d = IDLE;
            wr_d    = 1'b0;
            wait_d  = 1'b0;
            en_d    = 1'b0;
            xreq_d  = xvalid_q && !err_q && !trunc;
         end
      end else
         case (state_q)
            TYPE: if (acc) begin
               type_d  = bus.ioctl_dout;
               err_d   = err_q || bus.ioctl_dout >= 8'h20;
               state_d = (bus.ioctl_dout == 8'h00 || bus.ioctl_dout >= 8'h20) ? DRAIN : LEN;
            end
            LEN: if (acc) begin
               cnt_d   = type_q == 8'h01 ? {len_m2 == 8'h00, len_m2} : {bus.ioctl_dout == 8'h00, bus.ioctl_dout};
               state_d = type_q == 8'h01 ? ADLO : type_q == 8'h02 ? XLO : SKIP;
            end
            ADLO: if (acc) begin
               addr_d[7:0] = bus.ioctl_dout;
               state_d     = ADHI;
            end
            ADHI: if (acc) begin
               addr_d[15:8] = bus.ioctl_dout;
               state_d      = DATA;
            end
            DATA: if (acc) begin
               data_d  = bus.ioctl_dout;
               wr_d    = 1'b1;
               wait_d  = 1'b1;
               state_d = WRITE;
            end
            WRITE: if (bus.mem_ack) begin
               wr_d    = 1'b0;
               wait_d  = 1'b0;
               addr_d  = addr_q + 16'd1;
               cnt_d   = cnt_q - 9'd1;
               state_d = cnt_q == 9'd1 ? TYPE : DATA;
            end
            SKIP: if (acc) begin
               cnt_d   = cnt_q - 9'd1;
               state_d = cnt_q == 9'd1 ? TYPE : SKIP;
            end
            XLO: if (acc) begin
               xaddr_d[7:0] = bus.ioctl_dout;
               state_d      = XHI;
            end
            XHI: if (acc) begin
               xaddr_d[15:8] = bus.ioctl_dout;
               xvalid_d      = 1'b1;
               state_d       = DRAIN;
            end
            FLUSH: if (bus.mem_ack) begin
               state_d = IDLE;
               wr_d    = 1'b0;
               wait_d  = 1'b0;
               en_d    = 1'b0;
            end
            default: ;
         endcase
   end
endmodule

// File: tb/tb_cmd_loader.sv
// tb_cmd_loader: directed /CMD streams against hand-computed RAM writes, exec and error results
module tb_cmd_loader;
   logic        clk_sys = 1'b0;
   logic        reset   = 1'b0;
   int          n_chk = 0, n_ok = 0;
   int          dly = 0, wcnt = 0, unstable = 0, overlap = 0, run = 0, bad = 0;
   logic        pend = 1'b0;
   logic [15:0] pa, a_tmp;
   logic [7:0]  pd;
   logic [15:0] wa[$], ea[$];
   logic [7:0]  wd[$], ed[$], s[$];
   int          runs[$];
   cmd_loader_if bus();
   cmd_loader #(.CMD_INDEX(8'd2)) dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));
   always #5 clk_sys = ~clk_sys;
   // RAM model: acks after dly cycles, logs accepted writes, watches stability and wait runs
   always @(negedge clk_sys) begin
      if (!reset) begin
         pend = 1'b0;
         wcnt = 0;
      end
      bus.mem_ack = (dly == 0) || (bus.mem_wr && wcnt >= dly);
      wcnt = bus.mem_wr ? wcnt + 1 : 0;
      if (bus.mem_wr && bus.mem_ack) begin
         wa.push_back(bus.mem_addr);
         wd.push_back(bus.mem_data);
      end
      if (pend && (!bus.mem_wr || bus.mem_addr != pa || bus.mem_data != pd)) unstable++;
      pend = bus.mem_wr && !bus.mem_ack;
      pa = bus.mem_addr;
      pd = bus.mem_data;
      if (bus.ioctl_wait) run++;
      else if (run != 0) begin
         runs.push_back(run);
         run = 0;
      end
      if (bus.loader_en && bus.exec_req) overlap++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_ok++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask
   task automatic send(input logic [7:0] b);
      int t = 0;
      while (bus.ioctl_wait && t < 100) begin
         tick(1);
         t++;
      end
      if (t >= 100) chk("wait_to", t, 0);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_dout = b;
      tick(1);
      bus.ioctl_wr   = 1'b0;
   endtask
   task automatic send_all();
      foreach (s[i]) send(s[i]);
   endtask
   task automatic dl_start(input logic [7:0] idx);
      bus.ioctl_index    = idx;
      bus.ioctl_download = 1'b1;
      tick(1);
   endtask
   task automatic dl_end();
      int t = 0;
      tick(3);
      bus.ioctl_download = 1'b0;
      tick(1);
      while (bus.loader_en && t < 50) begin
         tick(1);
         t++;
      end
      if (t >= 50) chk("end_to", t, 0);
   endtask
   task automatic chk_wr(input string tag);
      int nb = 0;
      chk({tag, "_n"}, 32'(wa.size()), 32'(ea.size()));
      for (int i = 0; i < ea.size() && i < wa.size(); i++)
         if (wa[i] !== ea[i] || wd[i] !== ed[i]) nb++;
      chk({tag, "_bad"}, nb, 0);
      wa.delete();
      wd.delete();
      ea.delete();
      ed.delete();
   endtask
   initial begin
      bus.ioctl_download = 1'b0;
      bus.ioctl_index    = 8'h00;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_dout     = 8'h00;
      bus.exec_ack       = 1'b0;
      tick(2);
      chk("rst_wr", 32'(bus.mem_wr), 0);
      chk("rst_wait", 32'(bus.ioctl_wait), 0);
      chk("rst_en", 32'(bus.loader_en), 0);
      chk("rst_xreq", 32'(bus.exec_req), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_addr", 32'(bus.mem_addr), 0);
      reset = 1'b1;
      tick(2);
      // basic load with transfer block
      dl_start(8'd2);
      chk("t1_en", 32'(bus.loader_en), 1);
      s = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h2D, 8'h52};
      send_all();
      tick(2);
      chk("t1_xreq_early", 32'(bus.exec_req), 0);
      dl_end();
      chk("t1_xreq", 32'(bus.exec_req), 1);
      chk("t1_xaddr", 32'(bus.exec_addr), 32'h522D);
      chk("t1_err", 32'(bus.err), 0);
      chk("t1_en_off", 32'(bus.loader_en), 0);
      bus.exec_ack = 1'b1;
      tick(1);
      bus.exec_ack = 1'b0;
      chk("t1_xack", 32'(bus.exec_req), 0);
      ea = '{16'h5200, 16'h5201, 16'h5202};
      ed = '{8'hAA, 8'hBB, 8'hCC};
      chk_wr("t1_wr");
      // 256-byte block then a 254-byte block wrapping the address space
      dl_start(8'd2);
      s = '{8'h01, 8'h02, 8'h00, 8'h60};
      send_all();
      for (int i = 0; i < 256; i++) send(8'(i));
      s = '{8'h01, 8'h00, 8'hFF, 8'hFF};
      send_all();
      for (int i = 0; i < 254; i++) send(8'(i - 1));
      dl_end();
      for (int i = 0; i < 256; i++) begin
         ea.push_back(16'(16'h6000 + i));
         ed.push_back(8'(i));
      end
      for (int i = 0; i < 254; i++) begin
         a_tmp = 16'(16'hFFFF + i);
         ea.push_back(a_tmp);
         ed.push_back(a_tmp[7:0]);
      end
      chk_wr("t2_wr");
      chk("t2_err", 32'(bus.err), 0);
      chk("t2_xreq", 32'(bus.exec_req), 0);
      // skipped header record
      dl_start(8'd2);
      s = '{8'h05, 8'h03, 8'h41, 8'h42, 8'h43, 8'h01, 8'h03, 8'h00, 8'h70, 8'h11};
      send_all();
      dl_end();
      ea = '{16'h7000};
      ed = '{8'h11};
      chk_wr("t3_wr");
      chk("t3_xreq", 32'(bus.exec_req), 0);
      chk("t3_err", 32'(bus.err), 0);
      // slow RAM: 5-cycle ack delay
      dly = 5;
      tick(2);
      runs.delete();
      dl_start(8'd2);
      s = '{8'h01, 8'h04, 8'h00, 8'h80, 8'h12, 8'h34};
      send_all();
      tick(10);
      dl_end();
      ea = '{16'h8000, 16'h8001};
      ed = '{8'h12, 8'h34};
      chk_wr("t4_wr");
      bad = 0;
      foreach (runs[i]) if (runs[i] != 6) bad++;
      chk("t4_runs_n", 32'(runs.size()), 2);
      chk("t4_run_len", bad, 0);
      chk("t4_stable", unstable, 0);
      chk("t4_err", 32'(bus.err), 0);
      dly = 0;
      tick(2);
      // transfer-only file, then a new start clears the pending exec_req
      dl_start(8'd2);
      s = '{8'h02, 8'h02, 8'h34, 8'h12};
      send_all();
      dl_end();
      chk("t8_xreq", 32'(bus.exec_req), 1);
      chk("t8_xaddr", 32'(bus.exec_addr), 32'h1234);
      // truncated file
      dl_start(8'd2);
      chk("t5_xreq_clr", 32'(bus.exec_req), 0);
      chk("t5_en", 32'(bus.loader_en), 1);
      s = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA};
      send_all();
      dl_end();
      chk("t5_err", 32'(bus.err), 1);
      chk("t5_xreq", 32'(bus.exec_req), 0);
      chk("t5_en_off", 32'(bus.loader_en), 0);
      ea = '{16'h5200};
      ed = '{8'hAA};
      chk_wr("t5_wr");
      // illegal record type
      dl_start(8'd2);
      chk("t5b_err_clr", 32'(bus.err), 0);
      send(8'h2A);
      tick(1);
      chk("t5b_err_now", 32'(bus.err), 1);
      dl_end();
      chk("t5b_err", 32'(bus.err), 1);
      chk("t5b_xreq", 32'(bus.exec_req), 0);
      chk_wr("t5b_wr");
      // reset while a write is pending
      dly = 5;
      dl_start(8'd2);
      s = '{8'h01, 8'h03, 8'h00, 8'h90, 8'h55};
      send_all();
      chk("t6_wr_rise", 32'(bus.mem_wr), 1);
      chk("t6_addr", 32'(bus.mem_addr), 32'h9000);
      chk("t6_data", 32'(bus.mem_data), 32'h55);
      reset = 1'b0;
      #1;
      chk("t6_rst_wr", 32'(bus.mem_wr), 0);
      chk("t6_rst_wait", 32'(bus.ioctl_wait), 0);
      chk("t6_rst_en", 32'(bus.loader_en), 0);
      chk("t6_rst_addr", 32'(bus.mem_addr), 0);
      chk("t6_rst_data", 32'(bus.mem_data), 0);
      bus.ioctl_download = 1'b0;
      tick(2);
      reset = 1'b1;
      dly = 0;
      tick(2);
      chk("t6_idle_en", 32'(bus.loader_en), 0);
      chk_wr("t6_wr");
      // download with a foreign index
      dl_start(8'd1);
      s = '{8'h01, 8'h03, 8'h00, 8'h60, 8'h11};
      send_all();
      chk("t7_en", 32'(bus.loader_en), 0);
      chk("t7_wr", 32'(bus.mem_wr), 0);
      dl_end();
      chk_wr("t7_wr");
      chk("overlap", overlap, 0);
      chk("stable", unstable, 0);
      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end
endmodule
